// File: rtl/awgn_pkg.sv
// Shared fixed-point constants for the AWGN core (sqrt, trig and noise-multiply stages).
package awgn_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int F_W        = 17;
    localparam int G_W        = 16;
    localparam int OUT_W      = 16;

    localparam int F_FRAC     = 13;
    localparam int G_FRAC     = 15;
    localparam int OUT_FRAC   = 12;

    // Product has F_FRAC+G_FRAC fraction bits; dropping down to OUT_FRAC gives 16.
    localparam int RSHIFT     = F_FRAC + G_FRAC - OUT_FRAC;
    localparam int ROUND_BIAS = 1 << (RSHIFT - 1);

endpackage

// File: rtl/awgn_noise_mult_sync_fifo.sv
// Synchronous show-ahead FIFO used to align the f and (g0,g1) arrival streams.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_wr_s;
    logic         do_rd_s;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd_s = rd_en & ~empty;
    // A pop frees a slot in the same cycle, so a full FIFO may still accept.
    assign do_wr_s = wr_en & (~full | do_rd_s);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_wr_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/awgn_noise_mult.sv
// Box-Muller output stage: aligns f with (g0,g1), multiplies, rounds/saturates
// and serialises each (x0,x1) pair onto a valid/ready sample stream.
module awgn_noise_mult #(
    parameter int FIFO_DEPTH = awgn_pkg::FIFO_DEPTH,
    parameter int F_W        = awgn_pkg::F_W,
    parameter int G_W        = awgn_pkg::G_W,
    parameter int OUT_W      = awgn_pkg::OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [F_W-1:0]   f_in,
    input  logic             f_valid,
    input  logic [G_W-1:0]   g0_in,
    input  logic [G_W-1:0]   g1_in,
    input  logic             g_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic             sat
);

    import awgn_pkg::*;

    localparam int P_W = F_W + 1 + G_W;
    localparam logic signed [P_W-1:0] OUT_MAX =
        {{(P_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [P_W-1:0] OUT_MIN =
        {{(P_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Returns {clipped, value}: round half up, then clamp to the output range.
    function automatic logic [OUT_W:0] round_sat(input logic signed [P_W-1:0] p);
        logic signed [P_W-1:0] r;
        r = p + $signed(P_W'(ROUND_BIAS));
        r = r >>> RSHIFT;
        if (r > OUT_MAX) begin
            return {1'b1, OUT_MAX[OUT_W-1:0]};
        end else if (r < OUT_MIN) begin
            return {1'b1, OUT_MIN[OUT_W-1:0]};
        end else begin
            return {1'b0, r[OUT_W-1:0]};
        end
    endfunction

    logic               f_full_s, f_empty_s, g_full_s, g_empty_s;
    logic [F_W-1:0]     f_head_s;
    logic [2*G_W-1:0]   g_head_s;
    logic               f_wr_s, g_wr_s, f_drop_s, g_drop_s;
    logic               pop_s;
    logic               release_s, pair_load_s, s2_adv_s, s1_move_s, s1_adv_s;
    logic signed [P_W-1:0] m0_s, m1_s;
    logic [OUT_W:0]     r0_s, r1_s;

    logic               s1_valid_q, s1_valid_d;
    logic [F_W-1:0]     s1_f_q, s1_f_d;
    logic [G_W-1:0]     s1_g0_q, s1_g0_d, s1_g1_q, s1_g1_d;
    logic               s2_valid_q, s2_valid_d;
    logic signed [P_W-1:0] p0_q, p0_d, p1_q, p1_d;
    logic               pair_full_q, pair_full_d;
    logic [OUT_W-1:0]   x0_q, x0_d, x1_q, x1_d;
    logic               sel_q, sel_d;
    logic               sat_q, sat_d;
    logic               ovf_q, ovf_d;

    assign f_wr_s   = f_valid & (~f_full_s | pop_s);
    assign g_wr_s   = g_valid & (~g_full_s | pop_s);
    assign f_drop_s = f_valid & f_full_s & ~pop_s;
    assign g_drop_s = g_valid & g_full_s & ~pop_s;

    sync_fifo #(.DEPTH(FIFO_DEPTH), .W(F_W)) u_f_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (f_wr_s),
        .rd_en (pop_s),
        .wdata (f_in),
        .rdata (f_head_s),
        .full  (f_full_s),
        .empty (f_empty_s)
    );

    sync_fifo #(.DEPTH(FIFO_DEPTH), .W(2*G_W)) u_g_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (g_wr_s),
        .rd_en (pop_s),
        .wdata ({g0_in, g1_in}),
        .rdata (g_head_s),
        .full  (g_full_s),
        .empty (g_empty_s)
    );

    // Stall chain, evaluated from the output backwards.
    assign release_s   = pair_full_q & out_ready & sel_q;
    assign pair_load_s = s2_valid_q & (~pair_full_q | release_s);
    assign s2_adv_s    = ~s2_valid_q | pair_load_s;
    assign s1_move_s   = s1_valid_q & s2_adv_s;
    assign s1_adv_s    = ~s1_valid_q | s2_adv_s;
    assign pop_s       = ~f_empty_s & ~g_empty_s & s1_adv_s;

    // f is unsigned, so it gets a zero MSB before the signed multiply.
    assign m0_s = $signed({{(P_W-F_W){1'b0}}, s1_f_q}) *
                  $signed({{(P_W-G_W){s1_g0_q[G_W-1]}}, s1_g0_q});
    assign m1_s = $signed({{(P_W-F_W){1'b0}}, s1_f_q}) *
                  $signed({{(P_W-G_W){s1_g1_q[G_W-1]}}, s1_g1_q});
    assign r0_s = round_sat(p0_q);
    assign r1_s = round_sat(p1_q);

    // Next-state for the S1/S2 stages, the pair register and the status flags.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_f_d      = s1_f_q;
        s1_g0_d     = s1_g0_q;
        s1_g1_d     = s1_g1_q;
        s2_valid_d  = s2_valid_q;
        p0_d        = p0_q;
        p1_d        = p1_q;
        pair_full_d = pair_full_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        sel_d       = sel_q;
        sat_d       = pair_load_s & (r0_s[OUT_W] | r1_s[OUT_W]);
        ovf_d       = ovf_q | f_drop_s | g_drop_s;

        if (pop_s) begin
            s1_valid_d = 1'b1;
            s1_f_d     = f_head_s;
            s1_g0_d    = g_head_s[2*G_W-1:G_W];
            s1_g1_d    = g_head_s[G_W-1:0];
        end else if (s1_move_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s1_move_s) begin
            s2_valid_d = 1'b1;
            p0_d       = m0_s;
            p1_d       = m1_s;
        end else if (pair_load_s) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end

        if (pair_load_s) begin
            pair_full_d = 1'b1;
            sel_d       = 1'b0;
            x0_d        = r0_s[OUT_W-1:0];
            x1_d        = r1_s[OUT_W-1:0];
        end else if (pair_full_q && out_ready) begin
            if (sel_q) begin
                pair_full_d = 1'b0;
                sel_d       = 1'b0;
            end else begin
                sel_d       = 1'b1;
            end
        end else begin
            pair_full_d = pair_full_q;
        end
    end

    // Pipeline and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_f_q      <= '0;
            s1_g0_q     <= '0;
            s1_g1_q     <= '0;
            s2_valid_q  <= 1'b0;
            p0_q        <= '0;
            p1_q        <= '0;
            pair_full_q <= 1'b0;
            x0_q        <= '0;
            x1_q        <= '0;
            sel_q       <= 1'b0;
            sat_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_f_q      <= s1_f_d;
            s1_g0_q     <= s1_g0_d;
            s1_g1_q     <= s1_g1_d;
            s2_valid_q  <= s2_valid_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            pair_full_q <= pair_full_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            sel_q       <= sel_d;
            sat_q       <= sat_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = pair_full_q;
    assign out_data  = sel_q ? x1_q : x0_q;
    assign sat       = sat_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/awgn_noise_mult.md
# awgn_noise_mult

Final Box-Muller stage of the AWGN core. It consumes the unsigned magnitude f = sqrt(-2 ln u0) from the square-root unit and a (g0, g1) = (cos, sin)(2π u1) pair from the trig unit. Because the two paths have different fixed latencies, it aligns them, forms x0 = f·g0 and x1 = f·g1, then rounds and saturates the products. The result is emitted as a serial stream of 16-bit Gaussian noise samples with a valid/ready handshake toward the LDPC channel model.

## Interface
Parameters:
- FIFO_DEPTH, 8, entries in each alignment FIFO (power of two)
- F_W, 17, width of f, UQ4.13
- G_W, 16, width of g0/g1, signed Q1.15
- OUT_W, 16, output width, signed Q4.12

Ports:
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- f_in  in  F_W  sqrt magnitude
- f_valid  in  1  f_in qualifier; no backpressure upstream
- g0_in  in  G_W  cosine term
- g1_in  in  G_W  sine term
- g_valid  in  1  g0_in/g1_in qualifier; no backpressure upstream
- out_data  out  OUT_W  noise sample
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- ovf  out  1  sticky; an input was dropped on a full FIFO
- sat  out  1  one-cycle pulse; a sample entering the pair register was clipped

## Operation
- f FIFO: FIFO_DEPTH × F_W. g FIFO: FIFO_DEPTH × 2·G_W, packed {g0,g1}. Each writes on its valid when not full.
- A valid arriving on a full FIFO is dropped; ovf is set and stays at 1 until rst.
- Pairing: pop both heads together only when both FIFOs are non-empty and stage S1 can advance. Elements pair in arrival order; no other matching is performed.
- S1 registers f, g0 and g1.
- S2 registers P0 = {1'b0,f}·g0 and P1 = {1'b0,f}·g1. These are signed 18×16 products, 34 bits, 28 fraction bits.
- Round/saturate stage: R = (P + 2^15) >>> 16 (arithmetic shift), then clamp to [-32768, 32767]. sat pulses if either P0 or P1 clamps.
- The result loads into pair register {x0, x1, sel}.
- Pipeline is valid/stall: a stage advances when the next stage is empty or advancing. S2 → pair occurs when the pair register is empty or is releasing its last sample this cycle.
- Output: out_valid = pair full. out_data = sel ? x1 : x0.
  - On out_valid & out_ready with sel=0: sel ← 1.
  - On out_valid & out_ready with sel=1: pair empties and sel ← 0. A waiting S2 result may load in the same cycle.
- Order on out_data is always x0 then x1 of the same pair.

## Timing
- Reset values: out_valid=0, out_data=0, ovf=0, sat=0, sel=0, both FIFOs empty, all stage valids 0.
- rst mid-operation discards all in-flight data. Inputs presented in the rst cycle are ignored.
- Latency: f and g written at edge E into an empty, idle pipeline give S1 at E+1, S2 at E+2 and pair at E+3. out_valid is high in the cycle after E+3, showing x0; x1 follows on the next cycle if out_ready=1.
- Throughput: one sample per cycle, i.e. one pair per 2 cycles. Input rates of at most one f and one g per 2 cycles never overflow while out_ready=1.
- Capacity with out_ready held low: FIFO_DEPTH + S1 + S2 + pair = 11 pairs.
- Simultaneous write and pop on the same FIFO: legal at any occupancy, including full. A write to a full FIFO in a cycle where it pops is accepted.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH.

## Structure
- awgn_pkg holds shared constants: F_W, G_W, OUT_W, the Q-format fraction counts (13, 15, 12), ROUND_BIAS = 2^15 and RSHIFT = 16. The sqrt and trig units share the same constants.
- Sub-module sync_fifo (parameters DEPTH, W) is instantiated twice. It exposes wr_en, rd_en, wdata, rdata (show-ahead head), full and empty.
- Multipliers, round/saturate and the output serializer live in the top module.

## Test plan
- Basic pair: f=0x02000, g0=0x4000, g1=0xC000 in the same cycle. Expect out_data=0x0800 then 0xF800, with first out_valid 3 cycles after input and sat=0.
- Saturation: f=0x1FFFF, g0=0x7FFF, g1=0x8000. Expect 0x7FFF then 0x8000, with a single sat pulse when the pair loads.
- Misalignment: g arrives 5 cycles before each f over 20 pairs of random values. Expect outputs to match a reference model in order, with ovf=0.
- Backpressure: hold out_ready=0 while 12 f and 12 g arrive, one each per 2 cycles. Expect the first 11 accepted and the 12th to set ovf. On releasing out_ready, expect exactly 22 correct samples.
- Rounding tie: f=0x00002, g0=0x4000, giving P=2^15. Expect out_data=0x0001; with g1=0xC000, expect 0x0000.
- Reset mid-stream: assert rst for 1 cycle with the pair register and both FIFOs non-empty. Expect out_valid=0 and ovf=0 the next cycle, and no stale samples after resuming.
